// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture block.
package pwm_pkg;

    localparam int unsigned SPEED_W   = 16;
    localparam int unsigned MIN_SPEED = 256;
    localparam logic [15:0] MAX_SPEED = 16'hFFFF;

    typedef logic [SPEED_W-1:0] speed_t;

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        ACT       = 2'd1,
        INACT     = 2'd2
    } cap_state_t;

    // Saturating 16-bit increment; measurement counters never wrap.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Scale an active-time count to a speed word, clamping at full scale.
    function automatic speed_t scale_speed(input logic [15:0] a, input int unsigned shift);
        logic [31:0] w;
        w = {16'b0, a} << shift;
        return (w > {16'b0, MAX_SPEED}) ? MAX_SPEED : w[15:0];
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Result handoff bundle between the capture block and the speed pipeline.
interface pwm_capture_if;
    import pwm_pkg::*;

    logic   busy_in;
    speed_t speed_out;
    logic   speed_oe;
    logic   err_period;
    logic   sig_lost;

    modport master (
        input  busy_in,
        output speed_out,
        output speed_oe,
        output err_period,
        output sig_lost
    );

    modport slave (
        output busy_in,
        input  speed_out,
        input  speed_oe,
        input  err_period,
        input  sig_lost
    );

endinterface

// File: rtl/pwm_in_sync.sv
// Pin synchronizer, polarity map to "active" and registered edge detector.
module pwm_in_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_i,
    output logic act_o,
    output logic act_rise_o,
    output logic act_fall_o
);

    localparam logic ActLvl   = ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic InactLvl = ~ActLvl;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   act_q;
    logic                   act_prev_q;

    // Metastability chain; resets to the inactive pin level so reset never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{InactLvl}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
        end
    end

    // Registered active level and its one-cycle-old copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q      <= 1'b0;
            act_prev_q <= 1'b0;
        end else begin
            act_q      <= (sync_q[SYNC_STAGES-1] == ActLvl);
            act_prev_q <= act_q;
        end
    end

    assign act_o      = act_q;
    assign act_rise_o = act_q & ~act_prev_q;
    assign act_fall_o = ~act_q & act_prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Decodes a fixed-period PWM pin into 16-bit speed words with period and loss checks.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int unsigned PERIOD_CLKS  = 256,
    parameter int unsigned PERIOD_SHIFT = 8,
    parameter int unsigned PERIOD_TOL   = 4,
    parameter int unsigned TIMEOUT_CLKS = 1024,
    parameter bit          ACTIVE_LOW   = 1'b1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    pwm_capture_if.master cap_if
);

    localparam logic [15:0] PeriodW   = 16'(PERIOD_CLKS);
    localparam logic [15:0] TolW      = 16'(PERIOD_TOL);
    localparam logic [15:0] TimeoutM1 = 16'(TIMEOUT_CLKS - 1);

    logic act, act_rise, act_fall, any_edge;

    cap_state_t  state_q, state_d;
    logic [15:0] per_cnt_q, per_cnt_d;
    logic [15:0] act_cnt_q, act_cnt_d;
    logic [15:0] idle_cnt_q, idle_cnt_d;
    speed_t      result_q, result_d;
    logic        pending_q, pending_d;
    speed_t      speed_out_q, speed_out_d;
    logic        speed_oe_q, speed_oe_d;
    logic        err_q, err_d;
    logic        sig_lost_q, sig_lost_d;

    logic        timeout, eval_ok, new_valid, issue;
    speed_t      new_val;
    logic [15:0] per_diff;

    pwm_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .ACTIVE_LOW  (ACTIVE_LOW)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_i      (pwm_in),
        .act_o      (act),
        .act_rise_o (act_rise),
        .act_fall_o (act_fall)
    );

    assign any_edge = act_rise | act_fall;
    assign per_diff = (per_cnt_q >= PeriodW) ? (per_cnt_q - PeriodW) : (PeriodW - per_cnt_q);

    // Measurement FSM, timeout detection and result queuing.
    always_comb begin
        state_d    = state_q;
        per_cnt_d  = per_cnt_q;
        act_cnt_d  = act_cnt_q;
        idle_cnt_d = any_edge ? 16'd0 : sat_inc(idle_cnt_q);
        eval_ok    = 1'b0;
        err_d      = 1'b0;
        new_valid  = 1'b0;
        new_val    = '0;
        timeout    = !any_edge && (idle_cnt_q == TimeoutM1);

        unique case (state_q)
            WAIT_EDGE: begin
                if (act_rise) begin
                    per_cnt_d = 16'd1;
                    act_cnt_d = 16'd1;
                    state_d   = ACT;
                end
            end
            ACT: begin
                per_cnt_d = sat_inc(per_cnt_q);
                if (act) begin
                    act_cnt_d = sat_inc(act_cnt_q);
                end
                if (act_fall) begin
                    state_d = INACT;
                end
            end
            INACT: begin
                per_cnt_d = sat_inc(per_cnt_q);
                if (act_rise) begin
                    // per_cnt_q holds the exact rise-to-rise length of the finished period.
                    if (per_diff <= TolW) begin
                        eval_ok   = 1'b1;
                        new_valid = 1'b1;
                        new_val   = scale_speed(act_cnt_q, PERIOD_SHIFT);
                    end else begin
                        err_d = 1'b1;
                    end
                    per_cnt_d = 16'd1;
                    act_cnt_d = 16'd1;
                    state_d   = ACT;
                end
            end
            default: state_d = WAIT_EDGE;
        endcase

        if (timeout) begin
            state_d = WAIT_EDGE;
            // A dead inactive line asks downstream for a safe stop; stuck-active queues nothing.
            if (!act) begin
                new_valid = 1'b1;
                new_val   = '0;
            end
        end

        if (timeout) begin
            sig_lost_d = 1'b1;
        end else if (eval_ok) begin
            sig_lost_d = 1'b0;
        end else begin
            sig_lost_d = sig_lost_q;
        end
    end

    // Handoff: latest result wins; an issue in the same cycle as a new result keeps it pending.
    always_comb begin
        issue       = pending_q && !cap_if.busy_in;
        speed_oe_d  = issue;
        speed_out_d = issue ? result_q : speed_out_q;
        result_d    = new_valid ? new_val : result_q;
        if (new_valid) begin
            pending_d = 1'b1;
        end else if (issue) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_EDGE;
            per_cnt_q   <= '0;
            act_cnt_q   <= '0;
            idle_cnt_q  <= '0;
            result_q    <= '0;
            pending_q   <= 1'b0;
            speed_out_q <= '0;
            speed_oe_q  <= 1'b0;
            err_q       <= 1'b0;
            sig_lost_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            per_cnt_q   <= per_cnt_d;
            act_cnt_q   <= act_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            result_q    <= result_d;
            pending_q   <= pending_d;
            speed_out_q <= speed_out_d;
            speed_oe_q  <= speed_oe_d;
            err_q       <= err_d;
            sig_lost_q  <= sig_lost_d;
        end
    end

    assign cap_if.speed_out  = speed_out_q;
    assign cap_if.speed_oe   = speed_oe_q;
    assign cap_if.err_period = err_q;
    assign cap_if.sig_lost   = sig_lost_q;

endmodule
